// File: rtl/mems_pkg.sv
// mems_pkg: shared constants and types for the MEMS DAC SPI arbiter
//   DATA_W    SPI frame width
//   REQ_SCAN  requester id of the mirror scan sequencer
//   REQ_HOST  requester id of the host configuration path
//   state_e   arbiter FSM states
package mems_pkg;
    localparam int DATA_W = 24;
    localparam logic REQ_SCAN = 1'b0;
    localparam logic REQ_HOST = 1'b1;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_e;
endpackage

// File: rtl/mems_spi_req_slot.sv
// mems_spi_req_slot: one requester's latched frame, pending flag and overrun flag
//   clk, rst      clock, asynchronous active-high reset
//   start_i       one-cycle request pulse, data_i sampled with it
//   done_i        frame owned by this slot completed or timed out
//   err_clear_i   clears the sticky overrun flag
//   busy_o        slot occupied (pending or in flight)
//   data_o        latched frame
//   overrun_o     sticky: start arrived while the slot was occupied
module mems_spi_req_slot
    import mems_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              done_i,
    input  logic              err_clear_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              overrun_o
);
    logic              pend_q, pend_d, ovr_q, ovr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        pend_d = (start_i && !pend_q) ? 1'b1 : done_i ? 1'b0 : pend_q;
        data_d = (start_i && !pend_q) ? data_i : data_q;
        // a new overrun outranks a simultaneous clear
        ovr_d  = (start_i && pend_q) ? 1'b1 : err_clear_i ? 1'b0 : ovr_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            data_q <= data_d;
        end

    assign busy_o    = pend_q;
    assign data_o    = data_q;
    assign overrun_o = ovr_q;
endmodule

// File: rtl/mems_spi_arbiter.sv
// mems_spi_arbiter: shares one MEMS DAC SPI master between the scan and host requesters
//   clk, rst                           clock, asynchronous active-high reset
//   scan_start/scan_data/scan_busy     scan requester handshake
//   host_start/host_data/host_busy     host requester handshake
//   spi_start/spi_data/spi_busy        SPI master launch pulse, frame, busy
//   grant_host                         current/last owner is the host
//   timeout_err                        sticky: spi_busy never rose after a launch
//   overrun                            sticky [1]=host [0]=scan start while busy
//   err_clear                          clears timeout_err and overrun
module mems_spi_arbiter
    import mems_pkg::*;
#(
    parameter int HOST_BURST_MAX = 4,
    parameter int BUSY_TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_start,
    input  logic [DATA_W-1:0] scan_data,
    output logic              scan_busy,
    input  logic              host_start,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_busy,
    output logic              spi_start,
    output logic [DATA_W-1:0] spi_data,
    input  logic              spi_busy,
    output logic              grant_host,
    output logic              timeout_err,
    output logic [1:0]        overrun,
    input  logic              err_clear
);
    localparam int CW = $clog2(BUSY_TIMEOUT);
    localparam int SW = $clog2(HOST_BURST_MAX + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [DATA_W-1:0] spi_data_q, spi_data_d, scan_slot, host_slot;
    logic              grant_q, grant_d, start_q, start_d, tout_q, tout_d;
    logic              owner, done, timeout, fin, scan_ovr, host_ovr;

    assign fin = done | timeout;

    mems_spi_req_slot u_scan (
        .clk        (clk),
        .rst        (rst),
        .start_i    (scan_start),
        .data_i     (scan_data),
        .done_i     (fin && grant_q == REQ_SCAN),
        .err_clear_i(err_clear),
        .busy_o     (scan_busy),
        .data_o     (scan_slot),
        .overrun_o  (scan_ovr)
    );

    mems_spi_req_slot u_host (
        .clk        (clk),
        .rst        (rst),
        .start_i    (host_start),
        .data_i     (host_data),
        .done_i     (fin && grant_q == REQ_HOST),
        .err_clear_i(err_clear),
        .busy_o     (host_busy),
        .data_o     (host_slot),
        .overrun_o  (host_ovr)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        spi_data_d = spi_data_q;
        grant_d    = grant_q;
        done       = 1'b0;
        timeout    = 1'b0;
        // host wins unless scan is waiting and the host streak is exhausted
        owner      = (host_busy && !(scan_busy && streak_q == SW'(HOST_BURST_MAX))) ? REQ_HOST : REQ_SCAN;
        case (state_q)
            IDLE:
                if (scan_busy || host_busy) begin
                    state_d    = LAUNCH;
                    grant_d    = owner;
                    spi_data_d = (owner == REQ_HOST) ? host_slot : scan_slot;
                    streak_d   = (owner == REQ_SCAN) ? '0 :
                                 (streak_q == SW'(HOST_BURST_MAX)) ? streak_q : streak_q + 1'b1;
                end
            LAUNCH: begin
                state_d = WAIT_BUSY;
                cnt_d   = '0;
            end
            WAIT_BUSY:
                if (spi_busy)
                    state_d = WAIT_DONE;
                else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else
                    cnt_d = cnt_q + 1'b1;
            WAIT_DONE:
                if (!spi_busy) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            default: state_d = IDLE;
        endcase
        // registered launch pulse: high during the cycle after LAUNCH
        start_d = (state_q == LAUNCH);
        tout_d  = timeout | (tout_q & ~err_clear);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            streak_q   <= '0;
            spi_data_q <= '0;
            grant_q    <= 1'b0;
            start_q    <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            spi_data_q <= spi_data_d;
            grant_q    <= grant_d;
            start_q    <= start_d;
            tout_q     <= tout_d;
        end

    assign spi_start   = start_q;
    assign spi_data    = spi_data_q;
    assign grant_host  = grant_q;
    assign timeout_err = tout_q;
    assign overrun     = {host_ovr, scan_ovr};
endmodule

// File: tb/tb_mems_spi_arbiter.sv
// tb_mems_spi_arbiter: scoreboard bench with an SPI master model and a request-level reference model
module tb_mems_spi_arbiter;
    import mems_pkg::*;
    localparam int MAX = 4, TO = 16, BIG = 1 << 30;

    logic              clk = 0, rst = 1;
    logic              scan_start = 0, host_start = 0, spi_busy = 0, err_clear = 0;
    logic [DATA_W-1:0] scan_data = 0, host_data = 0;
    logic              scan_busy, host_busy, spi_start, grant_host, timeout_err;
    logic [DATA_W-1:0] spi_data;
    logic [1:0]        overrun;

    mems_spi_arbiter #(.HOST_BURST_MAX(MAX), .BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .scan_start(scan_start), .scan_data(scan_data), .scan_busy(scan_busy),
        .host_start(host_start), .host_data(host_data), .host_busy(host_busy),
        .spi_start(spi_start), .spi_data(spi_data), .spi_busy(spi_busy),
        .grant_host(grant_host), .timeout_err(timeout_err), .overrun(overrun),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                a;
    } req_t;

    req_t              scan_q[$], host_q[$];
    int                cyc = 0, vectors = 0, miscompares = 0;
    bit                occ[2];
    int                cedge[2];
    bit                exp_to, inflight, fl_host;
    logic [1:0]        exp_ov, ovs;
    logic [DATA_W-1:0] fl_data;
    int                streak, last_c = -100, to_edge = -1, b_on = 0, b_off = 0, fl_c = 0;
    int                cfg_mode = 0, cfg_d = 2, cfg_l = 30;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, want, cyc);
        end
    endtask

    // reference model: requests are accepted into a free slot; a slot is occupied
    // from its acceptance edge up to and including its completion edge
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            scan_q.delete();
            host_q.delete();
            occ[0] = 0; occ[1] = 0;
            cedge[0] = BIG; cedge[1] = BIG;
            exp_to = 0; exp_ov = 0; streak = 0; inflight = 0;
            last_c = -100; to_edge = -1; b_on = 0; b_off = 0;
        end else begin
            ovs = 0;
            if (scan_start) begin
                if (occ[0] && cedge[0] >= cyc) ovs[0] = 1;
                else begin
                    scan_q.push_back('{data: scan_data, a: cyc});
                    occ[0] = 1; cedge[0] = BIG;
                end
            end
            if (host_start) begin
                if (occ[1] && cedge[1] >= cyc) ovs[1] = 1;
                else begin
                    host_q.push_back('{data: host_data, a: cyc});
                    occ[1] = 1; cedge[1] = BIG;
                end
            end
            exp_ov = ovs | (exp_ov & ~{2{err_clear}});
            exp_to = (to_edge == cyc) | (exp_to & ~err_clear);
        end
    end

    // SPI master model: busy high after edge b_on up to edge b_off
    always @(posedge clk) begin
        #1;
        spi_busy = (cyc >= b_on && cyc < b_off);
    end

    task automatic launch();
        bit   h, s, wh, hang;
        int   e, first, d, l;
        req_t r;
        e = cyc;
        h = host_q.size() > 0 && host_q[0].a <= e - 2;
        s = scan_q.size() > 0 && scan_q[0].a <= e - 2;
        if (!h && !s) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_start: spi_start with no eligible request at cycle %0d", e);
            return;
        end
        first = BIG;
        if (host_q.size() > 0) first = host_q[0].a;
        if (scan_q.size() > 0 && scan_q[0].a < first) first = scan_q[0].a;
        chk("launch_cycle", 32'(e), 32'((first > last_c) ? first + 2 : last_c + 2));
        wh = h && !(s && streak == MAX);
        if (wh) r = host_q.pop_front();
        else r = scan_q.pop_front();
        chk("spi_data", 32'(spi_data), 32'(r.data));
        chk("grant_host", 32'(grant_host), 32'(wh));
        streak = wh ? ((streak < MAX) ? streak + 1 : MAX) : 0;
        hang = cfg_mode == 2 || (cfg_mode == 0 && $urandom_range(7) == 0);
        if (hang) begin
            b_on = 0; b_off = 0;
            fl_c = e + TO;
            to_edge = fl_c;
        end else begin
            d = (cfg_mode == 1) ? cfg_d : int'($urandom_range(3, 1));
            l = (cfg_mode == 1) ? cfg_l : int'($urandom_range(6, 1));
            b_on = e + d;
            b_off = b_on + l;
            fl_c = b_off + 1;
        end
        cedge[wh ? 1 : 0] = fl_c;
        last_c = fl_c;
        inflight = 1;
        fl_data = r.data;
        fl_host = wh;
    endtask

    // monitor: compares every cycle, pops the scoreboard on each launch
    always @(negedge clk) if (!rst) begin
        for (int s = 0; s < 2; s++) if (occ[s] && cedge[s] <= cyc) occ[s] = 0;
        chk("scan_busy", 32'(scan_busy), 32'(occ[0]));
        chk("host_busy", 32'(host_busy), 32'(occ[1]));
        chk("timeout_err", 32'(timeout_err), 32'(exp_to));
        chk("overrun", 32'(overrun), 32'(exp_ov));
        if (inflight && cyc < fl_c) begin
            chk("spi_data_hold", 32'(spi_data), 32'(fl_data));
            chk("grant_hold", 32'(grant_host), 32'(fl_host));
        end
        if (spi_start) launch();
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input bit s, input logic [DATA_W-1:0] sd, input bit h, input logic [DATA_W-1:0] hd);
        scan_start = s; scan_data = sd; host_start = h; host_data = hd;
        tick();
        scan_start = 0; host_start = 0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (scan_busy || host_busy || scan_q.size() > 0 || host_q.size() > 0 || spi_busy || cyc <= last_c + 1) begin
            if (n++ == bound) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_wait: still busy after %0d cycles", bound);
                return;
            end
            tick();
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_spi_start"}, 32'(spi_start), 0);
        chk({tag, "_spi_data"}, 32'(spi_data), 0);
        chk({tag, "_scan_busy"}, 32'(scan_busy), 0);
        chk({tag, "_host_busy"}, 32'(host_busy), 0);
        chk({tag, "_grant_host"}, 32'(grant_host), 0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
    endtask

    initial begin
        tick(3);
        chk_reset("rst");
        rst = 0;
        tick(5);
        // single scan frame, busy 2 cycles after start for 30 cycles
        cfg_mode = 1; cfg_d = 2; cfg_l = 30;
        req(1, 24'h300A55, 0, 0);
        wait_idle(100);
        // simultaneous requests: host first
        cfg_mode = 1; cfg_d = 1; cfg_l = 3;
        req(1, 24'h000111, 1, 24'h280001);
        wait_idle(100);
        // saturate the host streak, then a tie goes to scan
        for (int i = 0; i < 5; i++) begin
            req(0, 0, 1, 24'($urandom));
            wait_idle(100);
        end
        req(1, 24'h0A0A0A, 1, 24'h0B0B0B);
        wait_idle(100);
        for (int i = 0; i < 2; i++) begin
            req(0, 0, 1, 24'($urandom));
            wait_idle(100);
        end
        req(1, 24'h0C0C0C, 1, 24'h0D0D0D);
        wait_idle(100);
        // timeout, recovery, clear
        cfg_mode = 2;
        req(0, 0, 1, 24'h2A0000);
        wait_idle(100);
        cfg_mode = 1;
        req(1, 24'h123456, 0, 0);
        wait_idle(100);
        err_clear = 1;
        tick();
        err_clear = 0;
        tick(2);
        // timeout while err_clear is held: set wins for one cycle
        cfg_mode = 2;
        err_clear = 1;
        req(1, 24'h654321, 0, 0);
        wait_idle(100);
        err_clear = 0;
        tick(2);
        // overrun: second scan start with different data is dropped
        cfg_mode = 1; cfg_d = 2; cfg_l = 20;
        req(1, 24'hAAAAAA, 0, 0);
        tick(3);
        req(1, 24'h555555, 0, 0);
        wait_idle(100);
        chk("overrun_scan", 32'(overrun), 32'(2'b01));
        // start on the completion edge is an overrun
        cfg_d = 1; cfg_l = 3;
        req(0, 0, 1, 24'h111111);
        tick(6);
        req(0, 0, 1, 24'h222222);
        wait_idle(100);
        chk("overrun_both", 32'(overrun), 32'(2'b11));
        err_clear = 1;
        tick();
        err_clear = 0;
        // asynchronous reset in WAIT_DONE
        cfg_d = 1; cfg_l = 40;
        req(1, 24'h00BEEF, 1, 24'h3FFFFF);
        tick(10);
        req(1, 24'h00DEAD, 0, 0);
        tick(2);
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        chk_reset("async");
        tick(2);
        rst = 0;
        tick(20);
        cfg_d = 2; cfg_l = 3;
        req(1, 24'h0F0F0F, 0, 0);
        wait_idle(100);
        // randomized traffic
        cfg_mode = 0;
        for (int i = 0; i < 600; i++) begin
            scan_start = ($urandom_range(3) == 0);
            scan_data  = 24'($urandom);
            host_start = ($urandom_range(3) == 0);
            host_data  = 24'($urandom);
            err_clear  = ($urandom_range(15) == 0);
            tick();
        end
        scan_start = 0; host_start = 0; err_clear = 0;
        wait_idle(200);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "simulation time limit reached");
    end
endmodule
